stoplight_lamp_guard: RTL and testbench
=======================================

# stoplight_lamp_guard

Downstream safety stage between the stoplight state machine and the lamp drivers. It registers the six stoplight outputs through to the lamps and checks every input cycle for illegal patterns: conflicting right-of-way, malformed lamp sets, a skipped yellow, or a short yellow. On any violation it replaces the lamp outputs with a flashing-red failsafe and latches a fault code until software clears it. An illegal input pattern never reaches the lamps, not even for one cycle.

## Interface
- FLASH_HALF, 4: cycles per half-period of failsafe red flashing (≥1)
- MIN_YELLOW, 3: minimum consecutive yellow cycles required before a direction may go red (≥1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ns_red_in, ns_yellow_in, ns_green_in  in  1 each  north-south lamp requests from the stoplight controller
- ew_red_in, ew_yellow_in, ew_green_in  in  1 each  east-west lamp requests
- fault_clear  in  1  request to leave failsafe; level-sampled
- ns_red, ns_yellow, ns_green  out  1 each  registered north-south lamp drives
- ew_red, ew_yellow, ew_green  out  1 each  registered east-west lamp drives
- fault  out  1  high while in failsafe
- fault_code  out  3  first fault detected: 0 none, 1 malformed, 2 conflict, 3 skipped yellow, 4 short yellow

## Operation
- Reset values: ns_red=ew_red=1; all yellow/green lamp outputs=0; fault=0; fault_code=0; state=PASS; hist_valid=0; yellow counters=0; flash counter=0.
- State PASS: on each edge, lamp outputs load the current inputs, hist_valid←1, and prev_* registers load the inputs.
- Checks are evaluated combinationally on the current inputs and prev_*:
  - code 2, conflict: NS non-red and EW non-red in the same cycle (each direction has red_in=0).
  - code 1, malformed: either direction does not have exactly one of red/yellow/green asserted.
  - code 3, skipped yellow: for a direction, prev green=1 and now red=1; evaluated only when hist_valid=1.
  - code 4, short yellow: for a direction, prev yellow=1 and now red=1 and ycnt<MIN_YELLOW; evaluated only when hist_valid=1.
  - When several checks fail in the same cycle, priority is 2 > 1 > 3 > 4, and NS is evaluated before EW within a code.
- ycnt, one per direction: increments on each cycle that yellow_in=1, saturates at MIN_YELLOW, and clears when yellow_in=0. Width is clog2(MIN_YELLOW+1).
- PASS→FAULT when any check fails. On that same edge:
  - lamp outputs load the failsafe pattern, not the inputs: both red=1, all yellow/green=0;
  - fault←1 and fault_code←winning code;
  - flash counter←0 and red_on←1.
- State FAULT:
  - yellow/green outputs are held at 0; ns_red=ew_red=red_on.
  - flash counter counts 0..FLASH_HALF-1. On wrap it returns to 0 and red_on toggles.
  - Further check failures are ignored; fault_code keeps the first code.
- FAULT→PASS when fault_clear=1 and the current inputs pass codes 1 and 2. On that edge:
  - lamp outputs←inputs; fault←0; fault_code←0;
  - prev_*←inputs; hist_valid←0, so transition checks are skipped for the first PASS cycle;
  - ycnt continues to track the inputs.
  - If fault_clear=1 but the inputs are illegal, the block stays in FAULT and flashing continues undisturbed.
- fault_clear is ignored in PASS.
- Asserting reset mid-operation returns all registers to their reset values immediately, with no clock required.

## Timing
- PASS latency: input to lamp output is 1 cycle.
- Fault reaction: the violating input is sampled at edge N, and the lamps show failsafe from edge N onward. The lamps never show the violating pattern.
- Failsafe flashing: reds on for FLASH_HALF cycles, off for FLASH_HALF cycles, repeating. The first on-phase starts at the fault edge.
- Clear: fault_clear sampled at edge M; the lamps show the inputs, and fault=0, from edge M onward.
- First PASS cycle after reset or clear: only codes 1 and 2 are checked.

## Test plan
- Normal sequence (defaults): drive NS G×10, NS Y×4, EW G×7, EW Y×4, repeated twice -> lamps equal the inputs delayed by 1 cycle; fault stays 0 throughout.
- Conflict: during NS green, raise ew_green_in with ew_red_in=0 for one cycle -> at that edge lamps become both red, others 0; fault=1; fault_code=2; reds then toggle every 4 cycles.
- Skipped and short yellow: NS green→red directly -> fault_code=3. After reset, NS yellow for 2 cycles then red -> fault_code=4. NS yellow for 3 cycles then red -> no fault.
- Priority and latching: in one cycle drive both directions green plus ns_yellow_in=1 -> fault_code=2. Then apply a further malformed input -> fault_code stays 2.
- Clear: during FAULT, assert fault_clear with illegal inputs -> stays in FAULT. Then assert fault_clear with legal NS-green/EW-red inputs -> next edge lamps show NS green and EW red, fault=0, fault_code=0. An NS green→red on the immediately following cycle is not flagged as code 3.
- Async reset: assert reset mid-flash, between clock edges -> outputs go to reds=1, others 0, fault=0, fault_code=0 immediately. After release, the next checked transition starts with hist_valid=0.

Source files
------------

// File: rtl/stoplight_lamp_guard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stoplight_lamp_guard                                       |
// | Description : Safety stage between the stoplight controller and the     |
// |               lamp drivers. Registers the six lamp requests through to  |
// |               the lamps and checks each input cycle for conflicting     |
// |               right-of-way, malformed lamp sets, skipped yellow and     |
// |               short yellow. Any violation forces a flashing-red         |
// |               failsafe and latches the first fault code until cleared.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   FLASH_HALF     cycles per half-period of failsafe red flashing (>=1)   |
// |   MIN_YELLOW     minimum consecutive yellow cycles before red (>=1)      |
// | Ports                                                                    |
// |   clk_i          clock, rising edge                                      |
// |   reset_i        asynchronous active-high reset                          |
// |   ns_*_i, ew_*_i lamp requests from the stoplight controller             |
// |   fault_clear_i  level-sampled request to leave failsafe                 |
// |   ns_*_o, ew_*_o registered lamp drives                                  |
// |   fault_o        high while in failsafe                                  |
// |   fault_code_o   first fault: 0 none, 1 malformed, 2 conflict,           |
// |                  3 skipped yellow, 4 short yellow                        |
// +--------------------------------------------------------------------------+
module stoplight_lamp_guard #(
  parameter int FLASH_HALF = 4,
  parameter int MIN_YELLOW = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ns_red_i,
  input  logic       ns_yellow_i,
  input  logic       ns_green_i,
  input  logic       ew_red_i,
  input  logic       ew_yellow_i,
  input  logic       ew_green_i,
  input  logic       fault_clear_i,
  output logic       ns_red_o,
  output logic       ns_yellow_o,
  output logic       ns_green_o,
  output logic       ew_red_o,
  output logic       ew_yellow_o,
  output logic       ew_green_o,
  output logic       fault_o,
  output logic [2:0] fault_code_o
);

  // Yellow counters saturate at MIN_YELLOW; flash counter spans 0..FLASH_HALF-1.
  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  localparam logic [YW-1:0] C_YMAX  = YW'(MIN_YELLOW);
  localparam logic [FW-1:0] C_FLAST = FW'(FLASH_HALF - 1);

  localparam logic [2:0] C_CODE_NONE      = 3'd0;
  localparam logic [2:0] C_CODE_MALFORMED = 3'd1;
  localparam logic [2:0] C_CODE_CONFLICT  = 3'd2;
  localparam logic [2:0] C_CODE_SKIP      = 3'd3;
  localparam logic [2:0] C_CODE_SHORT     = 3'd4;

  // Lamp vector layout: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
  localparam logic [5:0] C_FAILSAFE = 6'b100_100;

  localparam logic [0:0] ST_PASS  = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [0:0]    state_q,      state_d;
  logic [5:0]    lamps_q,      lamps_d;
  logic [5:0]    prev_q,       prev_d;
  logic          hist_valid_q, hist_valid_d;
  logic          fault_q,      fault_d;
  logic [2:0]    code_q,       code_d;
  logic [FW-1:0] flash_q,      flash_d;
  logic          red_on_q,     red_on_d;
  logic [YW-1:0] ns_ycnt_q,    ns_ycnt_d;
  logic [YW-1:0] ew_ycnt_q,    ew_ycnt_d;

  // --------------------------------------------------------------------------
  // Combinational checks on the current inputs and the previous PASS cycle
  // --------------------------------------------------------------------------
  logic [5:0] w_in;
  logic       w_ns_onehot;
  logic       w_ew_onehot;
  logic       w_conflict;
  logic       w_malformed;
  logic       w_skip_ns;
  logic       w_skip_ew;
  logic       w_short_ns;
  logic       w_short_ew;
  logic       w_static_ok;
  logic [2:0] w_code;

  assign w_in = {ns_red_i, ns_yellow_i, ns_green_i, ew_red_i, ew_yellow_i, ew_green_i};

  // Exactly one of three: odd parity rules out 0 and 2 set, and the AND
  // term rules out all three set.
  assign w_ns_onehot = (^w_in[5:3]) & ~(&w_in[5:3]);
  assign w_ew_onehot = (^w_in[2:0]) & ~(&w_in[2:0]);

  assign w_conflict  = ~ns_red_i & ~ew_red_i;
  assign w_malformed = ~w_ns_onehot | ~w_ew_onehot;
  assign w_static_ok = ~w_conflict & ~w_malformed;

  // Transition checks need a valid previous cycle; the first PASS cycle after
  // reset or clear has none, so only the static checks apply there.
  assign w_skip_ns  = hist_valid_q & prev_q[3] & ns_red_i;
  assign w_skip_ew  = hist_valid_q & prev_q[0] & ew_red_i;
  assign w_short_ns = hist_valid_q & prev_q[4] & ns_red_i & (ns_ycnt_q < C_YMAX);
  assign w_short_ew = hist_valid_q & prev_q[1] & ew_red_i & (ew_ycnt_q < C_YMAX);

  always_comb begin
    w_code = C_CODE_NONE;
    if (w_conflict) begin
      w_code = C_CODE_CONFLICT;
    end else if (w_malformed) begin
      w_code = C_CODE_MALFORMED;
    end else if (w_skip_ns || w_skip_ew) begin
      w_code = C_CODE_SKIP;
    end else if (w_short_ns || w_short_ew) begin
      w_code = C_CODE_SHORT;
    end
  end

  // --------------------------------------------------------------------------
  // Yellow run counters: count consecutive yellow cycles up to MIN_YELLOW.
  // They track the inputs in every state, so a clear never resets them.
  // --------------------------------------------------------------------------
  always_comb begin
    ns_ycnt_d = '0;
    ew_ycnt_d = '0;
    if (ns_yellow_i) begin
      ns_ycnt_d = (ns_ycnt_q == C_YMAX) ? C_YMAX : ns_ycnt_q + 1'b1;
    end
    if (ew_yellow_i) begin
      ew_ycnt_d = (ew_ycnt_q == C_YMAX) ? C_YMAX : ew_ycnt_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_PASS;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PASS: begin
        if (w_code != C_CODE_NONE) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        // Leaving failsafe requires the inputs to be statically legal too.
        if (fault_clear_i && w_static_ok) begin
          state_d = ST_PASS;
        end
      end
      default: state_d = ST_FAULT;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs and history).
  // Decisions use the current-cycle checks so a violating pattern is replaced
  // by the failsafe on the very edge that samples it.
  // --------------------------------------------------------------------------
  always_comb begin
    lamps_d      = lamps_q;
    prev_d       = prev_q;
    hist_valid_d = hist_valid_q;
    fault_d      = fault_q;
    code_d       = code_q;
    flash_d      = flash_q;
    red_on_d     = red_on_q;

    case (state_q)
      ST_PASS: begin
        if (w_code != C_CODE_NONE) begin
          lamps_d  = C_FAILSAFE;
          fault_d  = 1'b1;
          code_d   = w_code;
          flash_d  = '0;
          red_on_d = 1'b1;
        end else begin
          lamps_d      = w_in;
          prev_d       = w_in;
          hist_valid_d = 1'b1;
        end
      end
      ST_FAULT: begin
        if (state_d == ST_PASS) begin
          lamps_d      = w_in;
          fault_d      = 1'b0;
          code_d       = C_CODE_NONE;
          prev_d       = w_in;
          hist_valid_d = 1'b0;
          flash_d      = '0;
          red_on_d     = 1'b1;
        end else begin
          // The fault edge showed red with count 0, so each phase lasts
          // FLASH_HALF edges before red_on flips.
          if (flash_q == C_FLAST) begin
            flash_d  = '0;
            red_on_d = ~red_on_q;
          end else begin
            flash_d = flash_q + 1'b1;
          end
          lamps_d = {red_on_d, 2'b00, red_on_d, 2'b00};
        end
      end
      default: begin
        lamps_d = C_FAILSAFE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lamps_q      <= C_FAILSAFE;
      prev_q       <= '0;
      hist_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      code_q       <= C_CODE_NONE;
      flash_q      <= '0;
      red_on_q     <= 1'b1;
      ns_ycnt_q    <= '0;
      ew_ycnt_q    <= '0;
    end else begin
      lamps_q      <= lamps_d;
      prev_q       <= prev_d;
      hist_valid_q <= hist_valid_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
      flash_q      <= flash_d;
      red_on_q     <= red_on_d;
      ns_ycnt_q    <= ns_ycnt_d;
      ew_ycnt_q    <= ew_ycnt_d;
    end
  end

  assign ns_red_o     = lamps_q[5];
  assign ns_yellow_o  = lamps_q[4];
  assign ns_green_o   = lamps_q[3];
  assign ew_red_o     = lamps_q[2];
  assign ew_yellow_o  = lamps_q[1];
  assign ew_green_o   = lamps_q[0];
  assign fault_o      = fault_q;
  assign fault_code_o = code_q;

endmodule
`default_nettype wire

// File: tb/tb_stoplight_lamp_guard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_stoplight_lamp_guard                                    |
// | Description : Self-checking bench for stoplight_lamp_guard: a fixed     |
// |               vector table, hand-written corner sequences and random    |
// |               stimulus compared against a behavioural model.            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_stoplight_lamp_guard;

  localparam int FH = 4;
  localparam int MY = 3;

  // Lamp vector layout: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
  localparam logic [5:0] NSG   = 6'b001_100;
  localparam logic [5:0] NSY   = 6'b010_100;
  localparam logic [5:0] ALR   = 6'b100_100;
  localparam logic [5:0] EWG   = 6'b100_001;
  localparam logic [5:0] EWY   = 6'b100_010;
  localparam logic [5:0] DARK  = 6'b000_000;
  localparam logic [5:0] BOTHG = 6'b001_001;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] in_v;
  logic       clr;
  logic       ns_red_o, ns_yellow_o, ns_green_o;
  logic       ew_red_o, ew_yellow_o, ew_green_o;
  logic       fault_o;
  logic [2:0] fault_code_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stoplight_lamp_guard #(.FLASH_HALF(FH), .MIN_YELLOW(MY)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .ns_red_i     (in_v[5]),
    .ns_yellow_i  (in_v[4]),
    .ns_green_i   (in_v[3]),
    .ew_red_i     (in_v[2]),
    .ew_yellow_i  (in_v[1]),
    .ew_green_i   (in_v[0]),
    .fault_clear_i(clr),
    .ns_red_o     (ns_red_o),
    .ns_yellow_o  (ns_yellow_o),
    .ns_green_o   (ns_green_o),
    .ew_red_o     (ew_red_o),
    .ew_yellow_o  (ew_yellow_o),
    .ew_green_o   (ew_green_o),
    .fault_o      (fault_o),
    .fault_code_o (fault_code_o)
  );

  // --------------------------------------------------------------------------
  // Behavioural model: tracks the fault entry cycle and yellow run lengths as
  // plain integers; the flash phase is derived from elapsed cycles.
  // --------------------------------------------------------------------------
  int         m_cyc;
  int         m_entry;
  int         m_yrun_ns;
  int         m_yrun_ew;
  logic       m_fault;
  logic [2:0] m_code;
  logic [5:0] m_prev;
  logic       m_hv;
  logic [5:0] m_lamps;

  task automatic model_reset();
    m_fault   = 1'b0;
    m_code    = 3'd0;
    m_prev    = 6'd0;
    m_hv      = 1'b0;
    m_yrun_ns = 0;
    m_yrun_ew = 0;
    m_lamps   = ALR;
  endtask

  task automatic model_step(input logic [5:0] v, input logic c);
    logic       conf, mal, skip, shrt, red;
    logic [2:0] code;
    conf = !v[5] && !v[2];
    mal  = ($countones(v[5:3]) != 1) || ($countones(v[2:0]) != 1);
    skip = m_hv && ((m_prev[3] && v[5]) || (m_prev[0] && v[2]));
    shrt = m_hv && ((m_prev[4] && v[5] && m_yrun_ns < MY) ||
                    (m_prev[1] && v[2] && m_yrun_ew < MY));
    code = conf ? 3'd2 : mal ? 3'd1 : skip ? 3'd3 : shrt ? 3'd4 : 3'd0;
    m_cyc++;
    if (!m_fault) begin
      if (code != 3'd0) begin
        m_fault = 1'b1;
        m_code  = code;
        m_entry = m_cyc;
        m_lamps = ALR;
      end else begin
        m_lamps = v;
        m_prev  = v;
        m_hv    = 1'b1;
      end
    end else if (c && !conf && !mal) begin
      m_fault = 1'b0;
      m_code  = 3'd0;
      m_lamps = v;
      m_prev  = v;
      m_hv    = 1'b0;
    end else begin
      red     = (((m_cyc - m_entry) / FH) % 2) == 0;
      m_lamps = {red, 2'b00, red, 2'b00};
    end
    m_yrun_ns = v[4] ? m_yrun_ns + 1 : 0;
    m_yrun_ew = v[1] ? m_yrun_ew + 1 : 0;
  endtask

  function automatic logic [9:0] dut_vec();
    return {ns_red_o, ns_yellow_o, ns_green_o, ew_red_o, ew_yellow_o,
            ew_green_o, fault_o, fault_code_o};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got lamps=%b fault=%b code=%0d, expected lamps=%b fault=%b code=%0d",
               name, act[9:4], act[3], act[2:0], exp[9:4], exp[3], exp[2:0]);
    end
  endtask

  // Drive inputs away from the edge, clock once, advance the model, sample at +1.
  task automatic tick(input logic [5:0] v, input logic c);
    in_v = v;
    clr  = c;
    @(posedge clk);
    model_step(v, c);
    #1;
  endtask

  task automatic tick_chk(input string name, input logic [5:0] v, input logic c);
    tick(v, c);
    check(name, dut_vec(), {m_lamps, m_fault, m_code});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("reset_state", dut_vec(), {ALR, 1'b0, 3'd0});
  endtask

  typedef struct {
    logic [5:0] in;
    logic       clr;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [5:0] legal[5];
    logic [5:0] pick;

    tbl[0]  = '{NSG,   1'b0, {NSG,  1'b0, 3'd0}};
    tbl[1]  = '{NSG,   1'b0, {NSG,  1'b0, 3'd0}};
    tbl[2]  = '{NSY,   1'b0, {NSY,  1'b0, 3'd0}};
    tbl[3]  = '{NSY,   1'b0, {NSY,  1'b0, 3'd0}};
    tbl[4]  = '{NSY,   1'b0, {NSY,  1'b0, 3'd0}};
    tbl[5]  = '{ALR,   1'b0, {ALR,  1'b0, 3'd0}};
    tbl[6]  = '{EWG,   1'b0, {EWG,  1'b0, 3'd0}};
    tbl[7]  = '{BOTHG, 1'b0, {ALR,  1'b1, 3'd2}};
    tbl[8]  = '{BOTHG, 1'b0, {ALR,  1'b1, 3'd2}};
    tbl[9]  = '{DARK,  1'b1, {ALR,  1'b1, 3'd2}};
    tbl[10] = '{6'b111_100, 1'b0, {ALR, 1'b1, 3'd2}};
    tbl[11] = '{NSG,   1'b0, {DARK, 1'b1, 3'd2}};
    tbl[12] = '{NSG,   1'b0, {DARK, 1'b1, 3'd2}};
    tbl[13] = '{NSG,   1'b0, {DARK, 1'b1, 3'd2}};
    tbl[14] = '{NSG,   1'b0, {DARK, 1'b1, 3'd2}};
    tbl[15] = '{NSG,   1'b0, {ALR,  1'b1, 3'd2}};
    tbl[16] = '{NSG,   1'b1, {NSG,  1'b0, 3'd0}};
    tbl[17] = '{ALR,   1'b0, {ALR,  1'b0, 3'd0}};
    tbl[18] = '{NSG,   1'b0, {NSG,  1'b0, 3'd0}};
    tbl[19] = '{ALR,   1'b0, {ALR,  1'b1, 3'd3}};

    legal[0] = NSG; legal[1] = NSY; legal[2] = ALR; legal[3] = EWG; legal[4] = EWY;

    m_cyc   = 0;
    m_entry = 0;
    model_reset();
    in_v  = ALR;
    clr   = 1'b0;
    reset = 1'b1;
    #12;
    check("reset_async", dut_vec(), {ALR, 1'b0, 3'd0});
    do_reset();

    // Table: legal sequence, conflict, flashing, clear, skipped yellow.
    for (int i = 0; i < 20; i++) begin
      tick(tbl[i].in, tbl[i].clr);
      check($sformatf("tbl[%0d]", i), dut_vec(), tbl[i].exp);
    end

    // Normal cycle twice: lamps follow inputs, no fault.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 10; k++) tick_chk("norm_nsg", NSG, 1'b0);
      for (int k = 0; k < 4; k++)  tick_chk("norm_nsy", NSY, 1'b0);
      for (int k = 0; k < 7; k++)  tick_chk("norm_ewg", EWG, 1'b0);
      for (int k = 0; k < 4; k++)  tick_chk("norm_ewy", EWY, 1'b0);
    end
    tick(NSG, 1'b0);
    check("norm_end", dut_vec(), {NSG, 1'b0, 3'd0});

    // Short yellow: two yellow cycles then red.
    do_reset();
    tick_chk("short_g", NSG, 1'b0);
    tick_chk("short_y1", NSY, 1'b0);
    tick_chk("short_y2", NSY, 1'b0);
    tick(ALR, 1'b0);
    check("short_code", dut_vec(), {ALR, 1'b1, 3'd4});

    // Exactly MIN_YELLOW yellow cycles then red: legal.
    do_reset();
    tick_chk("minY_g", NSG, 1'b0);
    for (int k = 0; k < MY; k++) tick_chk("minY_y", NSY, 1'b0);
    tick(ALR, 1'b0);
    check("minY_red", dut_vec(), {ALR, 1'b0, 3'd0});

    // Priority and latching: conflict plus malformed gives 2, later faults ignored.
    tick(6'b011_001, 1'b0);
    check("prio_code", dut_vec(), {ALR, 1'b1, 3'd2});
    tick(6'b111_111, 1'b0);
    check("latch_code", dut_vec(), {ALR, 1'b1, 3'd2});
    for (int k = 0; k < 4; k++) tick_chk("flash", NSG, 1'b0);

    // Async reset mid-flash (reds currently off), between edges.
    check("pre_reset_off", dut_vec(), {DARK, 1'b1, 3'd2});
    #2;
    reset = 1'b1;
    #1;
    check("midflash_reset", dut_vec(), {ALR, 1'b0, 3'd0});
    #1;
    reset = 1'b0;
    model_reset();
    tick_chk("post_rst_r", ALR, 1'b0);
    tick_chk("post_rst_g", NSG, 1'b0);
    tick(ALR, 1'b0);
    check("post_rst_skip", dut_vec(), {ALR, 1'b1, 3'd3});

    // Randomized stimulus against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 8) pick = legal[$urandom_range(0, 4)];
      else                          pick = 6'($urandom);
      tick_chk("rand", pick, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
